// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets three requesters share one UART transmitter.
// Each grant issues a single write trigger and then waits for a DONE edge or a timeout.
module uart_tx_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd60000
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic [7:0] DATA2,
  output logic [2:0] ACK,
  output logic       ERR,
  output logic       BUSY,
  output logic [1:0] GRANT,
  output logic [7:0] UART_DATA,
  output logic       UART_TRG,
  input  logic       UART_DONE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  data_q, data_d;
  logic        trg_q, trg_d;
  logic [15:0] timer_q, timer_d;
  logic        done_q, done_d;
  logic [1:0]  last_q, last_d;

  logic        done_rise;
  logic [1:0]  idx1, idx2, idx3;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [7:0]  win_data;

  // Only a fresh low-to-high transition counts; a level left high is stale.
  assign done_rise = UART_DONE & ~done_q;

  // Search order starts one past the last served requester and wraps mod 3.
  always_comb begin
    idx1 = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    idx2 = (idx1 == 2'd2) ? 2'd0 : idx1 + 2'd1;
    idx3 = last_q;
    win_found = 1'b1;
    win_idx   = 2'd0;
    if (REQ[idx1])      win_idx = idx1;
    else if (REQ[idx2]) win_idx = idx2;
    else if (REQ[idx3]) win_idx = idx3;
    else                win_found = 1'b0;
    case (win_idx)
      2'd0:    win_data = DATA0;
      2'd1:    win_data = DATA1;
      default: win_data = DATA2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    trg_d   = 1'b0;
    grant_d = grant_q;
    data_d  = data_q;
    timer_d = timer_q;
    last_d  = last_q;
    done_d  = UART_DONE;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          data_d  = win_data;
          trg_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A DONE edge takes precedence over a timeout in the same cycle.
        if (done_rise) begin
          ack_d   = 3'b001 << grant_q;
          last_d  = grant_q;
          state_d = S_RELEASE;
        end else if (timer_q == TIMEOUT_CYCLES - 16'd1) begin
          err_d   = 1'b1;
          last_d  = grant_q;
          state_d = S_RELEASE;
        end else if (timer_q != 16'hFFFF) begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ack_q   <= 3'b000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      grant_q <= 2'd0;
      data_q  <= 8'h00;
      trg_q   <= 1'b0;
      timer_q <= 16'd0;
      done_q  <= 1'b0;
      last_q  <= 2'd2;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      trg_q   <= trg_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      last_q  <= last_d;
    end
  end

  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign GRANT     = grant_q;
  assign UART_DATA = data_q;
  assign UART_TRG  = trg_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, single transfer, fairness, timeout,
// DONE/timeout race, reset during WAIT and stale DONE level.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       RST;
  logic [2:0] REQ;
  logic [7:0] DATA0, DATA1, DATA2;
  logic [2:0] ACK;
  logic       ERR, BUSY;
  logic [1:0] GRANT;
  logic [7:0] UART_DATA;
  logic       UART_TRG;
  logic       UART_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd100)) dut (
    .CLK_50MHZ (clk),
    .RST       (RST),
    .REQ       (REQ),
    .DATA0     (DATA0),
    .DATA1     (DATA1),
    .DATA2     (DATA2),
    .ACK       (ACK),
    .ERR       (ERR),
    .BUSY      (BUSY),
    .GRANT     (GRANT),
    .UART_DATA (UART_DATA),
    .UART_TRG  (UART_TRG),
    .UART_DONE (UART_DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    RST = 1'b0;
    REQ = 3'b000;
    UART_DONE = 1'b0;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
  endtask

  // Advances to the first negedge where the write trigger is high (bounded).
  task automatic wait_trg(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (UART_TRG === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 3'b000; UART_DONE = 1'b0;
    DATA0 = 8'h00; DATA1 = 8'h00; DATA2 = 8'h00;
    #3 RST = 1'b0;
    #1;
    n_checks++; if (UART_TRG !== 1'b0) begin n_fail++; $display("FAIL reset_trg: got %b expected 0", UART_TRG); end
    n_checks++; if (ACK !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", ACK); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", ERR); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_checks++; if (GRANT !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", GRANT); end
    n_checks++; if (UART_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", UART_DATA); end
    repeat (2) @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    n_checks++; if (BUSY !== 1'b0 || UART_TRG !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b trg=%b expected 0 0", BUSY, UART_TRG); end
    $display("reset: outputs idle after release");
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    DATA1 = 8'hA5;
    REQ = 3'b010;
    wait_trg(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_trg_timeout: got no trigger expected trigger"); end
    n_checks++; if (UART_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", UART_DATA); end
    n_checks++; if (GRANT !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d expected 1", GRANT); end
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", BUSY); end
    @(negedge clk);
    n_checks++; if (UART_TRG !== 1'b0) begin n_fail++; $display("FAIL single_trg_width: got %b expected 0", UART_TRG); end
    // Data changes and the request drops after the grant; neither may disturb the transfer.
    DATA1 = 8'h3C;
    REQ = 3'b000;
    repeat (19) @(negedge clk);
    UART_DONE = 1'b1;
    @(negedge clk);
    n_checks++; if (ACK !== 3'b010) begin n_fail++; $display("FAIL single_ack: got %b expected 010", ACK); end
    n_checks++; if (UART_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_data_hold: got %h expected a5", UART_DATA); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b expected 0", ERR); end
    UART_DONE = 1'b0;
    @(negedge clk);
    n_checks++; if (ACK !== 3'b000) begin n_fail++; $display("FAIL single_ack_width: got %b expected 000", ACK); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL single_busy_low: got %b expected 0", BUSY); end
    $display("single: grant=1 data=a5 ack=010");
  endtask

  task automatic test_contention();
    bit ok;
    logic [1:0] exp_g;
    logic [2:0] exp_a;
    do_reset();
    DATA0 = 8'h10; DATA1 = 8'h21; DATA2 = 8'h32;
    REQ = 3'b111;
    for (int i = 0; i < 4; i++) begin
      exp_g = 2'(i % 3);
      exp_a = 3'b001 << exp_g;
      wait_trg(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_trg_timeout[%0d]: got no trigger expected trigger", i); end
      n_checks++; if (GRANT !== exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, GRANT, exp_g); end
      @(negedge clk);
      UART_DONE = 1'b1;
      @(negedge clk);
      UART_DONE = 1'b0;
      n_checks++; if (ACK !== exp_a) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ACK, exp_a); end
      $display("contention: transfer %0d grant=%0d ack=%b", i, GRANT, ACK);
    end
    REQ = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    bit early_err;
    do_reset();
    DATA0 = 8'h77;
    REQ = 3'b001;
    wait_trg(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL to_trg_timeout: got no trigger expected trigger"); end
    @(negedge clk);
    early_err = (ERR !== 1'b0);
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (ERR !== 1'b0 || ACK !== 3'b000) early_err = 1'b1;
    end
    n_checks++; if (early_err) begin n_fail++; $display("FAIL to_early: got err/ack before 100 cycles expected none"); end
    @(negedge clk);
    n_checks++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", ERR); end
    n_checks++; if (ACK !== 3'b000) begin n_fail++; $display("FAIL to_ack: got %b expected 000", ACK); end
    @(negedge clk);
    n_checks++; if (ERR !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL to_after: got err=%b busy=%b expected 0 0", ERR, BUSY); end
    $display("timeout: err pulse after 100 wait cycles");
    wait_trg(ok);
    n_checks++; if (!ok || GRANT !== 2'd0) begin n_fail++; $display("FAIL to_regrant: got ok=%b grant=%0d expected 1 0", ok, GRANT); end
    @(negedge clk);
    UART_DONE = 1'b1;
    @(negedge clk);
    UART_DONE = 1'b0;
    REQ = 3'b000;
    n_checks++; if (ACK !== 3'b001) begin n_fail++; $display("FAIL to_regrant_ack: got %b expected 001", ACK); end
    $display("timeout: retry grant=0 ack=%b", ACK);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_race();
    bit ok;
    do_reset();
    REQ = 3'b001;
    wait_trg(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL race_trg_timeout: got no trigger expected trigger"); end
    repeat (100) @(negedge clk);
    UART_DONE = 1'b1;
    @(negedge clk);
    n_checks++; if (ACK !== 3'b001) begin n_fail++; $display("FAIL race_ack: got %b expected 001", ACK); end
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL race_err: got %b expected 0", ERR); end
    UART_DONE = 1'b0;
    REQ = 3'b000;
    @(negedge clk);
    n_checks++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL race_err_late: got %b expected 0", ERR); end
    $display("race: done on last timer cycle ack=001 err=0");
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    bit ok;
    do_reset();
    DATA0 = 8'h11; DATA1 = 8'h22; DATA2 = 8'h33;
    REQ = 3'b001;
    wait_trg(ok);
    @(negedge clk);
    UART_DONE = 1'b1;
    @(negedge clk);
    UART_DONE = 1'b0;
    REQ = 3'b000;
    @(negedge clk);
    REQ = 3'b010;
    wait_trg(ok);
    n_checks++; if (!ok || GRANT !== 2'd1) begin n_fail++; $display("FAIL rw_pre_grant: got ok=%b grant=%0d expected 1 1", ok, GRANT); end
    repeat (5) @(negedge clk);
    #2 RST = 1'b0;
    #1;
    n_checks++; if (BUSY !== 1'b0 || GRANT !== 2'd0 || UART_DATA !== 8'h00) begin n_fail++; $display("FAIL rw_async: got busy=%b grant=%0d data=%h expected 0 0 00", BUSY, GRANT, UART_DATA); end
    n_checks++; if (ACK !== 3'b000 || ERR !== 1'b0 || UART_TRG !== 1'b0) begin n_fail++; $display("FAIL rw_async_pulses: got ack=%b err=%b trg=%b expected 000 0 0", ACK, ERR, UART_TRG); end
    REQ = 3'b101;
    repeat (3) @(negedge clk);
    RST = 1'b1;
    wait_trg(ok);
    n_checks++; if (!ok || GRANT !== 2'd0) begin n_fail++; $display("FAIL rw_first_grant: got ok=%b grant=%0d expected 1 0", ok, GRANT); end
    n_checks++; if (UART_DATA !== 8'h11) begin n_fail++; $display("FAIL rw_data: got %h expected 11", UART_DATA); end
    @(negedge clk);
    UART_DONE = 1'b1;
    @(negedge clk);
    UART_DONE = 1'b0;
    REQ = 3'b000;
    n_checks++; if (ACK !== 3'b001) begin n_fail++; $display("FAIL rw_ack: got %b expected 001", ACK); end
    $display("reset_wait: post-reset grant=0 ack=%b", ACK);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stale_done();
    bit ok;
    bit stale_ack;
    do_reset();
    UART_DONE = 1'b1;
    @(negedge clk);
    DATA2 = 8'h5A;
    REQ = 3'b100;
    wait_trg(ok);
    n_checks++; if (!ok || GRANT !== 2'd2) begin n_fail++; $display("FAIL stale_grant: got ok=%b grant=%0d expected 1 2", ok, GRANT); end
    stale_ack = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ACK !== 3'b000) stale_ack = 1'b1;
    end
    n_checks++; if (stale_ack) begin n_fail++; $display("FAIL stale_level: got ack on held level expected none"); end
    UART_DONE = 1'b0;
    @(negedge clk);
    UART_DONE = 1'b1;
    @(negedge clk);
    n_checks++; if (ACK !== 3'b100) begin n_fail++; $display("FAIL stale_fresh_ack: got %b expected 100", ACK); end
    n_checks++; if (UART_DATA !== 8'h5A) begin n_fail++; $display("FAIL stale_data: got %h expected 5a", UART_DATA); end
    $display("stale: fresh edge ack=%b", ACK);
    UART_DONE = 1'b0;
    REQ = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_race();
    test_reset_wait();
    test_stale_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
